// File: rtl/serpent_pkg.sv
// Shared constants and helpers for the Serpent round-key storage.
package serpent_pkg;

    localparam int SERPENT_KEY_W       = 128;
    localparam int SERPENT_NUM_SUBKEYS = 33;

    // Bank-select width; a single bank still gets a 1-bit select port.
    function automatic int bank_w_f(input int num_banks);
        return (num_banks > 1) ? $clog2(num_banks) : 1;
    endfunction

endpackage

// File: rtl/rkey_bank.sv
// One bank of round keys: DEPTH x KEY_W storage, per-entry valid bitmap with
// bulk clear, and a registered read-first read port. Callers only strobe this
// bank with in-range addresses.
module rkey_bank #(
    parameter int KEY_W  = 128,
    parameter int DEPTH  = 33,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [KEY_W-1:0]  wr_key_i,
    input  logic              clr_en_i,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [KEY_W-1:0]  rd_key_o,
    output logic              rd_miss_o,
    output logic              ready_o
);

    logic [KEY_W-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0] vld_q;
    logic [DEPTH-1:0] vld_d;
    logic [KEY_W-1:0] rd_key_q;

    // Key storage; contents survive reset, only the valid bits are cleared.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_key_i;
        end
    end

    // Read-first port: samples pre-edge data and valid; invalid entries read as zero.
    always_ff @(posedge clk_i) begin
        if (rd_en_i) begin
            rd_key_q <= vld_q[rd_addr_i] ? mem_q[rd_addr_i] : '0;
        end
    end

    // Valid next state: a clear wipes the bank first so a same-cycle write survives.
    always_comb begin
        vld_d = vld_q;
        if (clr_en_i) begin
            vld_d = '0;
        end
        if (wr_en_i) begin
            vld_d[wr_addr_i] = 1'b1;
        end
    end

    // Valid bitmap register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            vld_q <= '0;
        end else begin
            vld_q <= vld_d;
        end
    end

    assign rd_key_o  = rd_key_q;
    assign rd_miss_o = rd_en_i & ~vld_q[rd_addr_i];
    assign ready_o   = &vld_q;

endmodule

// File: rtl/serpent_rkey_store.sv
// Multi-bank round-key store: range-checks every strobe, steers legal accesses
// to one rkey_bank per key set, and muxes the registered read data out.
module serpent_rkey_store
    import serpent_pkg::*;
#(
    parameter int KEY_W     = SERPENT_KEY_W,
    parameter int DEPTH     = SERPENT_NUM_SUBKEYS,
    parameter int NUM_BANKS = 2,
    parameter int ADDR_W    = $clog2(DEPTH),
    parameter int BANK_W    = bank_w_f(NUM_BANKS)
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_wr_en,
    input  logic [BANK_W-1:0]    i_wr_bank,
    input  logic [ADDR_W-1:0]    i_wr_addr,
    input  logic [KEY_W-1:0]     i_wr_key,
    input  logic                 i_clr_en,
    input  logic [BANK_W-1:0]    i_clr_bank,
    input  logic                 i_rd_en,
    input  logic [BANK_W-1:0]    i_rd_bank,
    input  logic [ADDR_W-1:0]    i_rd_addr,
    output logic [KEY_W-1:0]     o_rd_key,
    output logic                 o_rd_valid,
    output logic [NUM_BANKS-1:0] o_bank_ready,
    output logic                 o_err
);

    logic                 wr_ok;
    logic                 clr_ok;
    logic                 rd_ok;
    logic                 err_d;
    logic [KEY_W-1:0]     bank_key [NUM_BANKS];
    logic [NUM_BANKS-1:0] bank_miss;
    logic [NUM_BANKS-1:0] bank_ready;

    logic                 rd_vld_q;
    logic                 err_q;
    logic                 rd_zero_q;
    logic [BANK_W-1:0]    rd_bank_q;
    logic [KEY_W-1:0]     rd_key;

    assign wr_ok  = (32'(i_wr_addr) < DEPTH) && (32'(i_wr_bank) < NUM_BANKS);
    assign clr_ok = (32'(i_clr_bank) < NUM_BANKS);
    assign rd_ok  = (32'(i_rd_addr) < DEPTH) && (32'(i_rd_bank) < NUM_BANKS);

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic bank_wr;
        logic bank_clr;
        logic bank_rd;

        assign bank_wr  = i_wr_en  && wr_ok  && (32'(i_wr_bank)  == b);
        assign bank_clr = i_clr_en && clr_ok && (32'(i_clr_bank) == b);
        assign bank_rd  = i_rd_en  && rd_ok  && (32'(i_rd_bank)  == b);

        rkey_bank #(
            .KEY_W  (KEY_W),
            .DEPTH  (DEPTH),
            .ADDR_W (ADDR_W)
        ) u_bank (
            .clk_i     (i_clk),
            .rst_ni    (i_rst_n),
            .wr_en_i   (bank_wr),
            .wr_addr_i (i_wr_addr),
            .wr_key_i  (i_wr_key),
            .clr_en_i  (bank_clr),
            .rd_en_i   (bank_rd),
            .rd_addr_i (i_rd_addr),
            .rd_key_o  (bank_key[b]),
            .rd_miss_o (bank_miss[b]),
            .ready_o   (bank_ready[b])
        );
    end

    // Error sources: any out-of-range strobe, or a legal read of an invalid entry.
    always_comb begin
        err_d = (i_wr_en  & ~wr_ok)
              | (i_clr_en & ~clr_ok)
              | (i_rd_en  & ~rd_ok)
              | (|bank_miss);
    end

    // Read-side control: remembers which bank answers and whether the answer is forced to zero.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            rd_vld_q  <= 1'b0;
            err_q     <= 1'b0;
            rd_zero_q <= 1'b1;
            rd_bank_q <= '0;
        end else begin
            rd_vld_q <= i_rd_en;
            err_q    <= err_d;
            if (i_rd_en) begin
                rd_zero_q <= ~rd_ok;
                if (rd_ok) begin
                    rd_bank_q <= i_rd_bank;
                end
            end
        end
    end

    // Output mux; the selected bank's read register holds between reads, so the key holds too.
    always_comb begin
        rd_key = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (32'(rd_bank_q) == 32'(b)) begin
                rd_key = bank_key[b];
            end
        end
        if (rd_zero_q) begin
            rd_key = '0;
        end
    end

    assign o_rd_key     = rd_key;
    assign o_rd_valid   = rd_vld_q;
    assign o_err        = err_q;
    assign o_bank_ready = bank_ready;

endmodule

// File: tb/tb_serpent_rkey_store.sv
// Self-checking bench for serpent_rkey_store: default 2x33 instance against an
// array-based reference model, plus a 4x8 instance for generalisation.
module tb_serpent_rkey_store;

    localparam int KW  = 128;
    localparam int D   = 33;
    localparam int NB  = 2;
    localparam int GD  = 8;
    localparam int GNB = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          wr_en, clr_en, rd_en;
    logic [0:0]    wr_bank, clr_bank, rd_bank;
    logic [5:0]    wr_addr, rd_addr;
    logic [KW-1:0] wr_key;
    logic [KW-1:0] rd_key;
    logic          rd_valid, err;
    logic [NB-1:0] bank_ready;

    logic           g_wr_en, g_clr_en, g_rd_en;
    logic [1:0]     g_wr_bank, g_clr_bank, g_rd_bank;
    logic [2:0]     g_wr_addr, g_rd_addr;
    logic [KW-1:0]  g_wr_key;
    logic [KW-1:0]  g_rd_key;
    logic           g_rd_valid, g_err;
    logic [GNB-1:0] g_bank_ready;

    serpent_rkey_store dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_wr_en(wr_en), .i_wr_bank(wr_bank), .i_wr_addr(wr_addr), .i_wr_key(wr_key),
        .i_clr_en(clr_en), .i_clr_bank(clr_bank),
        .i_rd_en(rd_en), .i_rd_bank(rd_bank), .i_rd_addr(rd_addr),
        .o_rd_key(rd_key), .o_rd_valid(rd_valid), .o_bank_ready(bank_ready), .o_err(err)
    );

    serpent_rkey_store #(.KEY_W(KW), .DEPTH(GD), .NUM_BANKS(GNB)) dut_g (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_wr_en(g_wr_en), .i_wr_bank(g_wr_bank), .i_wr_addr(g_wr_addr), .i_wr_key(g_wr_key),
        .i_clr_en(g_clr_en), .i_clr_bank(g_clr_bank),
        .i_rd_en(g_rd_en), .i_rd_bank(g_rd_bank), .i_rd_addr(g_rd_addr),
        .o_rd_key(g_rd_key), .o_rd_valid(g_rd_valid), .o_bank_ready(g_bank_ready), .o_err(g_err)
    );

    int checks = 0;
    int passed = 0;

    // Reference model of the default instance.
    logic [KW-1:0] m_key [NB][D];
    bit            m_vld [NB][D];
    logic [KW-1:0] exp_key;
    logic          exp_rv;
    logic          exp_err;

    function automatic logic [NB-1:0] exp_ready();
        logic [NB-1:0] r;
        for (int b = 0; b < NB; b++) begin
            r[b] = 1'b1;
            for (int a = 0; a < D; a++) if (!m_vld[b][a]) r[b] = 1'b0;
        end
        return r;
    endfunction

    task automatic model_edge();
        logic nerr;
        nerr = 1'b0;
        if (!rst_n) begin
            for (int b = 0; b < NB; b++) for (int a = 0; a < D; a++) m_vld[b][a] = 1'b0;
            exp_key = '0; exp_rv = 1'b0; exp_err = 1'b0;
            return;
        end
        if (rd_en) begin
            exp_rv = 1'b1;
            if (int'(rd_addr) < D && m_vld[rd_bank][rd_addr]) exp_key = m_key[rd_bank][rd_addr];
            else begin exp_key = '0; nerr = 1'b1; end
        end else begin
            exp_rv = 1'b0;
        end
        if (clr_en) for (int a = 0; a < D; a++) m_vld[clr_bank][a] = 1'b0;
        if (wr_en) begin
            if (int'(wr_addr) < D) begin
                m_key[wr_bank][wr_addr] = wr_key;
                m_vld[wr_bank][wr_addr] = 1'b1;
            end else begin
                nerr = 1'b1;
            end
        end
        exp_err = nerr;
    endtask

    task automatic idle();
        wr_en = 0; wr_bank = 0; wr_addr = 0; wr_key = '0;
        clr_en = 0; clr_bank = 0; rd_en = 0; rd_bank = 0; rd_addr = 0;
        g_wr_en = 0; g_wr_bank = 0; g_wr_addr = 0; g_wr_key = '0;
        g_clr_en = 0; g_clr_bank = 0; g_rd_en = 0; g_rd_bank = 0; g_rd_addr = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    function automatic logic [KW-1:0] rnd_key();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        tick(); tick();
        checks++;
        if ({rd_key, rd_valid, err, bank_ready} !== {{KW{1'b0}}, 1'b0, 1'b0, 2'b00})
            $display("FAIL reset: key=%h v=%b e=%b rdy=%b, want all zero", rd_key, rd_valid, err, bank_ready);
        else passed++;
        checks++;
        if ({g_rd_key, g_rd_valid, g_err, g_bank_ready} !== {{KW{1'b0}}, 1'b0, 1'b0, 4'b0000})
            $display("FAIL reset_g: key=%h v=%b e=%b rdy=%b, want all zero", g_rd_key, g_rd_valid, g_err, g_bank_ready);
        else passed++;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_fill();
        for (int i = 0; i <= D; i++) begin
            idle();
            if (i < D) begin wr_en = 1; wr_bank = 0; wr_addr = 6'(i); wr_key = {16{8'(i)}}; end
            if (i > 0) begin rd_en = 1; rd_bank = 0; rd_addr = 6'(i - 1); end
            tick();
            checks++;
            if ({rd_key, rd_valid, err, bank_ready} !== {exp_key, exp_rv, exp_err, exp_ready()})
                $display("FAIL fill_model i=%0d: key=%h v=%b e=%b rdy=%b, want key=%h v=%b e=%b rdy=%b",
                         i, rd_key, rd_valid, err, bank_ready, exp_key, exp_rv, exp_err, exp_ready());
            else passed++;
            checks++;
            if (bank_ready !== ((i >= D - 1) ? 2'b01 : 2'b00))
                $display("FAIL fill_ready i=%0d: rdy=%b, want %b", i, bank_ready, (i >= D - 1) ? 2'b01 : 2'b00);
            else passed++;
            if (i > 0) begin
                checks++;
                if ({rd_key, rd_valid, err} !== {{16{8'(i - 1)}}, 1'b1, 1'b0})
                    $display("FAIL fill_read a=%0d: key=%h v=%b e=%b, want key=%h v=1 e=0",
                             i - 1, rd_key, rd_valid, err, {16{8'(i - 1)}});
                else passed++;
            end
        end
    endtask

    task automatic test_read_during_write();
        logic [KW-1:0] a_key;
        a_key = rnd_key();
        idle();
        wr_en = 1; wr_bank = 0; wr_addr = 5; wr_key = a_key;
        rd_en = 1; rd_bank = 0; rd_addr = 5;
        tick();
        checks++;
        if ({rd_key, rd_valid, err} !== {{16{8'h05}}, 1'b1, 1'b0})
            $display("FAIL rdw_old: key=%h v=%b e=%b, want key=%h v=1 e=0", rd_key, rd_valid, err, {16{8'h05}});
        else passed++;
        idle();
        rd_en = 1; rd_bank = 0; rd_addr = 5;
        tick();
        checks++;
        if ({rd_key, rd_valid, err} !== {a_key, 1'b1, 1'b0})
            $display("FAIL rdw_new: key=%h v=%b e=%b, want key=%h v=1 e=0", rd_key, rd_valid, err, a_key);
        else passed++;
        idle();
        tick();
        checks++;
        if ({rd_key, rd_valid} !== {a_key, 1'b0})
            $display("FAIL hold: key=%h v=%b, want key=%h v=0", rd_key, rd_valid, a_key);
        else passed++;
    endtask

    task automatic test_back_to_back_clear();
        logic [KW-1:0] k;
        for (int i = 0; i < D; i++) begin
            idle();
            wr_en = 1; wr_bank = 1; wr_addr = 6'(i); wr_key = rnd_key();
            rd_en = 1; rd_bank = 0; rd_addr = 6'(i);
            tick();
            checks++;
            if ({rd_key, rd_valid, err, bank_ready} !== {exp_key, exp_rv, exp_err, exp_ready()} || rd_valid !== 1'b1)
                $display("FAIL b2b i=%0d: key=%h v=%b e=%b rdy=%b, want key=%h v=1 e=%b rdy=%b",
                         i, rd_key, rd_valid, err, bank_ready, exp_key, exp_err, exp_ready());
            else passed++;
        end
        checks++;
        if (bank_ready !== 2'b11) $display("FAIL both_ready: rdy=%b, want 11", bank_ready);
        else passed++;
        k = rnd_key();
        idle();
        clr_en = 1; clr_bank = 1; wr_en = 1; wr_bank = 1; wr_addr = 0; wr_key = k;
        tick();
        checks++;
        if ({bank_ready, err} !== {2'b01, 1'b0}) $display("FAIL clr_wr: rdy=%b e=%b, want rdy=01 e=0", bank_ready, err);
        else passed++;
        idle();
        rd_en = 1; rd_bank = 1; rd_addr = 0;
        tick();
        checks++;
        if ({rd_key, rd_valid, err} !== {k, 1'b1, 1'b0})
            $display("FAIL clr_rd0: key=%h v=%b e=%b, want key=%h v=1 e=0", rd_key, rd_valid, err, k);
        else passed++;
        rd_addr = 1;
        tick();
        checks++;
        if ({rd_key, rd_valid, err} !== {{KW{1'b0}}, 1'b1, 1'b1})
            $display("FAIL clr_rd1: key=%h v=%b e=%b, want key=0 v=1 e=1", rd_key, rd_valid, err);
        else passed++;
    endtask

    task automatic test_illegal();
        for (int i = 0; i < 3; i++) begin
            idle();
            wr_en = 1; wr_bank = 0; wr_addr = 40; wr_key = rnd_key();
            rd_en = 1; rd_bank = 0; rd_addr = 33;
            tick();
            checks++;
            if ({rd_key, rd_valid, err, bank_ready} !== {{KW{1'b0}}, 1'b1, 1'b1, 2'b01})
                $display("FAIL illegal i=%0d: key=%h v=%b e=%b rdy=%b, want key=0 v=1 e=1 rdy=01",
                         i, rd_key, rd_valid, err, bank_ready);
            else passed++;
        end
        idle();
        rd_en = 1; rd_bank = 0; rd_addr = 8;
        tick();
        checks++;
        if ({rd_key, rd_valid, err} !== {{16{8'h08}}, 1'b1, 1'b0})
            $display("FAIL illegal_nochg: key=%h v=%b e=%b, want key=%h v=1 e=0", rd_key, rd_valid, err, {16{8'h08}});
        else passed++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            idle();
            wr_en = 1'($urandom_range(0, 1)); wr_bank = 1'($urandom);
            wr_addr = 6'($urandom_range(0, 35)); wr_key = rnd_key();
            clr_en = ($urandom_range(0, 15) == 0); clr_bank = 1'($urandom);
            rd_en = ($urandom_range(0, 9) < 6); rd_bank = 1'($urandom);
            rd_addr = 6'($urandom_range(0, 35));
            tick();
            checks++;
            if ({rd_key, rd_valid, err, bank_ready} !== {exp_key, exp_rv, exp_err, exp_ready()})
                $display("FAIL random i=%0d: key=%h v=%b e=%b rdy=%b, want key=%h v=%b e=%b rdy=%b",
                         i, rd_key, rd_valid, err, bank_ready, exp_key, exp_rv, exp_err, exp_ready());
            else passed++;
        end
    endtask

    task automatic test_reset_midfill();
        for (int i = 0; i < D; i++) begin
            idle();
            wr_en = 1; wr_bank = 0; wr_addr = 6'(i); wr_key = rnd_key();
            tick();
        end
        idle();
        wr_en = 1; wr_bank = 1; wr_addr = 3; wr_key = rnd_key();
        rd_en = 1; rd_bank = 0; rd_addr = 2;
        rst_n = 1'b0;
        tick();
        checks++;
        if ({rd_key, rd_valid, err, bank_ready} !== {{KW{1'b0}}, 1'b0, 1'b0, 2'b00})
            $display("FAIL midfill_rst: key=%h v=%b e=%b rdy=%b, want all zero", rd_key, rd_valid, err, bank_ready);
        else passed++;
        rst_n = 1'b1;
        idle();
        rd_en = 1; rd_bank = 0; rd_addr = 2;
        tick();
        checks++;
        if ({rd_key, rd_valid, err} !== {{KW{1'b0}}, 1'b1, 1'b1})
            $display("FAIL midfill_rd: key=%h v=%b e=%b, want key=0 v=1 e=1", rd_key, rd_valid, err);
        else passed++;
    endtask

    task automatic test_generic();
        logic [KW-1:0]  gk [GNB][GD];
        logic [GNB-1:0] want;
        for (int b = 0; b < GNB; b++) begin
            for (int a = 0; a < GD; a++) begin
                idle();
                gk[b][a] = rnd_key();
                g_wr_en = 1; g_wr_bank = 2'(b); g_wr_addr = 3'(a); g_wr_key = gk[b][a];
                tick();
                want = '0;
                for (int j = 0; j < GNB; j++) if (j < b || (j == b && a == GD - 1)) want[j] = 1'b1;
                checks++;
                if (g_bank_ready !== want) $display("FAIL g_ready b=%0d a=%0d: rdy=%b, want %b", b, a, g_bank_ready, want);
                else passed++;
            end
        end
        for (int i = 0; i < GNB * GD; i++) begin
            idle();
            g_rd_en = 1; g_rd_bank = 2'(i / GD); g_rd_addr = 3'(i % GD);
            tick();
            checks++;
            if ({g_rd_key, g_rd_valid, g_err} !== {gk[i / GD][i % GD], 1'b1, 1'b0})
                $display("FAIL g_read i=%0d: key=%h v=%b e=%b, want key=%h v=1 e=0",
                         i, g_rd_key, g_rd_valid, g_err, gk[i / GD][i % GD]);
            else passed++;
        end
        idle();
        g_clr_en = 1; g_clr_bank = 2;
        tick();
        checks++;
        if (g_bank_ready !== 4'b1011) $display("FAIL g_clr: rdy=%b, want 1011", g_bank_ready);
        else passed++;
        idle();
        g_rd_en = 1; g_rd_bank = 2; g_rd_addr = 3;
        tick();
        checks++;
        if ({g_rd_key, g_rd_valid, g_err} !== {{KW{1'b0}}, 1'b1, 1'b1})
            $display("FAIL g_clr_rd: key=%h v=%b e=%b, want key=0 v=1 e=1", g_rd_key, g_rd_valid, g_err);
        else passed++;
        idle();
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        test_reset();
        test_fill();
        test_read_during_write();
        test_back_to_back_clear();
        test_illegal();
        test_random();
        test_reset_midfill();
        test_generic();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
